// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared state, opcode, ALU and writeback encodings
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [2:0] M2R_ALU   = 3'b000;
    localparam logic [2:0] M2R_PC4   = 3'b001;
    localparam logic [2:0] M2R_IMM   = 3'b010;
    localparam logic [2:0] M2R_PCIMM = 3'b011;
    localparam logic [2:0] M2R_LB    = 3'b100;
    localparam logic [2:0] M2R_LH    = 3'b101;
    localparam logic [2:0] M2R_LW    = 3'b110;
    localparam logic [2:0] M2R_SLT   = 3'b111;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_RS1   = 2'b10;

    // ALU operation for R-type / I-ALU instructions. sub_sel is funct7[5]
    // for R-type and forced 0 for immediates (no SUBI).
    function automatic logic [2:0] alu_op(input logic [2:0] funct3, input logic sub_sel);
        case (funct3)
            3'b000:  alu_op = sub_sel ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SUB;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    endfunction

    function automatic logic branch_cond(input logic [2:0] funct3, input logic zero, input logic neg);
        case (funct3)
            3'b000:  branch_cond = zero;
            3'b001:  branch_cond = !zero;
            3'b100:  branch_cond = neg;
            3'b101:  branch_cond = !neg;
            default: branch_cond = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctl_decode.sv
// rtl/ctl_decode.sv - combinational instruction decode from IR and latched taken flag
//
// Ports:
//   ir         in   latched instruction word
//   taken      in   branch outcome latched in EXEC
//   alu_ctl    out  ALU operation code
//   alu_src    out  ALU B operand select (1 = immediate)
//   mem_to_reg out  writeback source select
//   pc_src     out  next-PC select used in WB
//   reg_write  out  instruction writes rd
//   is_mem     out  load or store (visits MEM)
//   is_store   out  store
//   is_branch  out  conditional branch
//   is_halt    out  EBREAK
//   is_illegal out  opcode not recognised
module ctl_decode
    import multicycle_control_pkg::*;
(
    input  logic [31:0] ir,
    input  logic        taken,
    output logic [2:0]  alu_ctl,
    output logic        alu_src,
    output logic [2:0]  mem_to_reg,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        is_mem,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_ir_bits;

    assign opcode         = ir[6:0];
    assign funct3         = ir[14:12];
    assign funct7_b5      = ir[30];
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    always_comb begin
        alu_ctl    = ALU_ADD;
        alu_src    = 1'b0;
        mem_to_reg = M2R_ALU;
        pc_src     = PC_PLUS4;
        reg_write  = 1'b0;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                alu_ctl   = alu_op(funct3, funct7_b5);
                if (funct3 == 3'b010) mem_to_reg = M2R_SLT;
            end
            OP_IALU: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = alu_op(funct3, 1'b0);
                if (funct3 == 3'b010) mem_to_reg = M2R_SLT;
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                is_mem     = 1'b1;
                mem_to_reg = M2R_LW;
            end
            OP_STORE: begin
                alu_src  = 1'b1;
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_BRANCH: begin
                alu_ctl   = ALU_SUB;
                is_branch = 1'b1;
                pc_src    = taken ? PC_REL : PC_PLUS4;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC4;
                pc_src     = PC_REL;
            end
            OP_JALR: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                mem_to_reg = M2R_PC4;
                pc_src     = PC_RS1;
            end
            OP_LUI: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_IMM;
            end
            OP_AUIPC: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_PCIMM;
            end
            OP_SYSTEM: is_halt    = 1'b1;
            default:   is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start                pulse that leaves IDLE
//   im_data              instruction word, captured in FETCH
//   ALUzero, ALUneg      datapath flags, sampled in EXEC for branches
//   dm_ack               data memory completion, honoured only in MEM
//   run                  PC-advance enable (WB only)
//   RegWrite, ALUsrc     datapath controls
//   PCsrc, MemtoReg      next-PC and writeback selects
//   ALUctl               ALU operation
//   dm_req, dm_we        data memory request / write strobe
//   busy, halted, illegal status
//   retired              retired-instruction count (wraps)
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  im_data,
    input  logic         ALUzero,
    input  logic         ALUneg,
    input  logic         dm_ack,
    output logic         run,
    output logic         RegWrite,
    output logic         ALUsrc,
    output logic [1:0]   PCsrc,
    output logic [2:0]   MemtoReg,
    output logic [2:0]   ALUctl,
    output logic         dm_req,
    output logic         dm_we,
    output logic         busy,
    output logic         halted,
    output logic         illegal,
    output logic [W-1:0] retired
);

    state_t      state, next_state;
    logic [31:0] ir;
    logic        taken;
    logic        illegal_q;
    logic [W-1:0] retired_q;

    logic [2:0]  dec_alu_ctl;
    logic        dec_alu_src;
    logic [2:0]  dec_mem_to_reg;
    logic [1:0]  dec_pc_src;
    logic        dec_reg_write;
    logic        dec_is_mem;
    logic        dec_is_store;
    logic        dec_is_branch;
    logic        dec_is_halt;
    logic        dec_is_illegal;

    ctl_decode u_decode (
        .ir         (ir),
        .taken      (taken),
        .alu_ctl    (dec_alu_ctl),
        .alu_src    (dec_alu_src),
        .mem_to_reg (dec_mem_to_reg),
        .pc_src     (dec_pc_src),
        .reg_write  (dec_reg_write),
        .is_mem     (dec_is_mem),
        .is_store   (dec_is_store),
        .is_branch  (dec_is_branch),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: next_state = (dec_is_halt || dec_is_illegal) ? S_HALT : S_EXEC;
            S_EXEC:   next_state = dec_is_mem ? S_MEM : S_WB;
            S_MEM:    if (dm_ack) next_state = S_WB;
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    // Instruction register, branch outcome, sticky illegal flag and retire count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir        <= '0;
            taken     <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state == S_FETCH) ir <= im_data;
            if (state == S_EXEC)
                taken <= dec_is_branch && branch_cond(ir[14:12], ALUzero, ALUneg);
            if (state == S_DECODE && dec_is_illegal) illegal_q <= 1'b1;
            if (state == S_WB) retired_q <= retired_q + 1'b1;
        end
    end

    // ALU controls stay valid from EXEC through WB so the address/result
    // seen by memory and the register file is stable.
    always_comb begin
        run      = 1'b0;
        RegWrite = 1'b0;
        ALUsrc   = 1'b0;
        PCsrc    = PC_PLUS4;
        MemtoReg = M2R_ALU;
        ALUctl   = 3'b000;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        case (state)
            S_EXEC: begin
                ALUctl = dec_alu_ctl;
                ALUsrc = dec_alu_src;
            end
            S_MEM: begin
                ALUctl = dec_alu_ctl;
                ALUsrc = dec_alu_src;
                dm_req = 1'b1;
                dm_we  = dec_is_store;
            end
            S_WB: begin
                ALUctl   = dec_alu_ctl;
                ALUsrc   = dec_alu_src;
                run      = 1'b1;
                RegWrite = dec_reg_write;
                MemtoReg = dec_mem_to_reg;
                PCsrc    = dec_pc_src;
            end
            default: ;
        endcase
    end

    assign busy    = (state != S_IDLE) && (state != S_HALT);
    assign halted  = (state == S_HALT);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] im_data;
    logic        ALUzero, ALUneg, dm_ack;
    logic        run, RegWrite, ALUsrc;
    logic [1:0]  PCsrc;
    logic [2:0]  MemtoReg, ALUctl;
    logic        dm_req, dm_we, busy, halted, illegal;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    int nret   = 0;

    multicycle_control #(.W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .im_data  (im_data),
        .ALUzero  (ALUzero),
        .ALUneg   (ALUneg),
        .dm_ack   (dm_ack),
        .run      (run),
        .RegWrite (RegWrite),
        .ALUsrc   (ALUsrc),
        .PCsrc    (PCsrc),
        .MemtoReg (MemtoReg),
        .ALUctl   (ALUctl),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .busy     (busy),
        .halted   (halted),
        .illegal  (illegal),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        neg;
        logic [2:0]  aluctl;
        logic        alusrc;
        logic [2:0]  m2r;
        logic [1:0]  pcsrc;
        logic        rw;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at the negedge of MEM's first cycle; raises dm_ack on the
    // ack_cycle-th MEM cycle and counts how long dm_req was held.
    task automatic mem_phase(input string tag, input int ack_cycle, input logic exp_we);
        int n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!dm_req) break;
            n++;
            check({tag, "_dm_we"}, dm_we, exp_we);
            dm_ack = (n == ack_cycle);
            step();
        end
        dm_ack = 1'b0;
        check({tag, "_req_cycles"}, n, ack_cycle);
    endtask

    initial begin
        vecs[0] = '{32'h00500093, 1'b0, 1'b0, 3'b010, 1'b1, 3'b000, 2'b00, 1'b1}; // ADDI x1,x0,5
        vecs[1] = '{32'h00000463, 1'b1, 1'b0, 3'b110, 1'b0, 3'b000, 2'b01, 1'b0}; // BEQ taken
        vecs[2] = '{32'h00001463, 1'b1, 1'b0, 3'b110, 1'b0, 3'b000, 2'b00, 1'b0}; // BNE not taken
        vecs[3] = '{32'h00004463, 1'b0, 1'b1, 3'b110, 1'b0, 3'b000, 2'b01, 1'b0}; // BLT taken
        vecs[4] = '{32'h000080E7, 1'b0, 1'b0, 3'b010, 1'b1, 3'b001, 2'b10, 1'b1}; // JALR
        vecs[5] = '{32'h40000033, 1'b0, 1'b0, 3'b110, 1'b0, 3'b000, 2'b00, 1'b1}; // SUB
        vecs[6] = '{32'h003120B3, 1'b0, 1'b0, 3'b110, 1'b0, 3'b111, 2'b00, 1'b1}; // SLT
        vecs[7] = '{32'h00006033, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 2'b00, 1'b1}; // OR
        vecs[8] = '{32'h0000F093, 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 2'b00, 1'b1}; // ANDI

        rst = 1'b0; start = 1'b0; im_data = 32'h0;
        ALUzero = 1'b0; ALUneg = 1'b0; dm_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_run", run, 1'b0);
        check("rst_retired", retired, 32'd0);
        check("rst_illegal", illegal, 1'b0);
        rst = 1'b1;
        step();
        check("idle_busy", busy, 1'b0);

        start = 1'b1;
        im_data = vecs[0].instr;
        step();
        start = 1'b0;
        check("fetch_busy", busy, 1'b1);
        check("fetch_aluctl", ALUctl, 3'b000);

        // Each iteration starts at the negedge of a FETCH cycle.
        for (int i = 0; i < 9; i++) begin
            im_data = vecs[i].instr;
            ALUzero = vecs[i].zero;
            ALUneg  = vecs[i].neg;
            step();
            check($sformatf("v%0d_decode_alusrc", i), ALUsrc, 1'b0);
            step();
            check($sformatf("v%0d_exec_aluctl", i), ALUctl, vecs[i].aluctl);
            check($sformatf("v%0d_exec_alusrc", i), ALUsrc, vecs[i].alusrc);
            check($sformatf("v%0d_exec_run", i), run, 1'b0);
            step();
            check($sformatf("v%0d_wb_run", i), run, 1'b1);
            check($sformatf("v%0d_wb_regwrite", i), RegWrite, vecs[i].rw);
            check($sformatf("v%0d_wb_memtoreg", i), MemtoReg, vecs[i].m2r);
            check($sformatf("v%0d_wb_pcsrc", i), PCsrc, vecs[i].pcsrc);
            step();
            nret++;
            check($sformatf("v%0d_retired", i), retired, nret);
            check($sformatf("v%0d_fetch_run", i), run, 1'b0);
        end

        // LW x1,0(x0), ack on the 4th MEM cycle.
        im_data = 32'h00002083;
        ALUzero = 1'b0; ALUneg = 1'b0;
        step();
        step();
        check("lw_exec_alusrc", ALUsrc, 1'b1);
        check("lw_exec_aluctl", ALUctl, 3'b010);
        step();
        mem_phase("lw", 4, 1'b0);
        check("lw_wb_run", run, 1'b1);
        check("lw_wb_memtoreg", MemtoReg, 3'b110);
        check("lw_wb_regwrite", RegWrite, 1'b1);
        step();
        nret++;
        check("lw_retired", retired, nret);

        // SW x1,0(x0), ack on the 2nd MEM cycle.
        im_data = 32'h00102023;
        step();
        step();
        step();
        mem_phase("sw", 2, 1'b1);
        check("sw_wb_run", run, 1'b1);
        check("sw_wb_regwrite", RegWrite, 1'b0);
        step();
        nret++;
        check("sw_retired", retired, nret);

        // EBREAK halts; a later start is ignored.
        im_data = 32'h00100073;
        step();
        step();
        check("ebreak_halted", halted, 1'b1);
        check("ebreak_busy", busy, 1'b0);
        check("ebreak_run", run, 1'b0);
        check("ebreak_illegal", illegal, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("halt_start_halted", halted, 1'b1);
        check("halt_start_busy", busy, 1'b0);
        check("halt_start_retired", retired, nret);

        // Illegal opcode 0x7F.
        rst = 1'b0;
        #1;
        check("rst_async_halted", halted, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        im_data = 32'h0000007F;
        step();
        start = 1'b0;
        step();
        step();
        check("illegal_halted", halted, 1'b1);
        check("illegal_flag", illegal, 1'b1);
        check("illegal_retired", retired, 32'd0);

        // Reset in the middle of a MEM wait.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst2_illegal", illegal, 1'b0);
        start = 1'b1;
        im_data = 32'h00002083;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("mid_mem_req", dm_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_dm_req", dm_req, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_alusrc", ALUsrc, 1'b0);
        check("mid_rst_aluctl", ALUctl, 3'b000);
        check("mid_rst_retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        im_data = 32'h00500093;
        step();
        start = 1'b0;
        check("restart_busy", busy, 1'b1);
        check("restart_retired", retired, 32'd0);
        step();
        step();
        step();
        check("restart_wb_run", run, 1'b1);
        step();
        check("restart_retired_1", retired, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter W, default 32, is the datapath word width and is used only for the retired-instruction counter.
REQ-002 clk  input  1  sole clock, all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that starts execution from IDLE.
REQ-005 im_data  input  32  current instruction word from instruction memory.
REQ-006 ALUzero, ALUneg  input  1 each  datapath flags.
REQ-007 dm_ack  input  1  data memory completion for the current request.
REQ-008 run  output  1  PC-advance enable to the datapath.
REQ-009 RegWrite, ALUsrc  output  1 each  datapath controls.
REQ-010 PCsrc  output  2  00 = PC+4, 01 = PC+imm, 10 = rs1+imm.
REQ-011 MemtoReg  output  3  writeback select: 000 alu, 001 PC+4, 010 imm, 011 PC+imm, 100 LB, 101 LH, 110 LW, 111 SLT.
REQ-012 ALUctl  output  3  ALU operation code.
REQ-013 dm_req, dm_we  output  1 each  memory request and write strobe.
REQ-014 busy, halted, illegal  output  1 each  status flags.
REQ-015 retired  output  W  count of retired instructions.

Function
REQ-016 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; the state register is binary-encoded.
REQ-017 IDLE moves to FETCH on start=1; otherwise it stays in IDLE.
REQ-018 FETCH moves to DECODE and captures im_data into an internal instruction register (IR); all later decode uses IR only.
REQ-019 DECODE classifies the opcode:
- ADD/R-type 0110011, ADDI 0010011, JALR 1100111, LW 0000011, SW 0100011, BEQ-class 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, EBREAK 1110011.
- EBREAK goes to HALT.
- Any other opcode goes to HALT and sets illegal=1.
- All others go to EXEC.
REQ-020 EXEC drives ALUctl/ALUsrc for the instruction, then goes to MEM for LW/SW and to WB otherwise.
- In EXEC, branches latch taken from funct3: 000 ALUzero, 001 !ALUzero, 100 ALUneg, 101 !ALUneg, others not-taken.
REQ-021 MEM holds dm_req=1 (and dm_we=1 for SW) until dm_ack=1 is sampled, then goes to WB; there is no timeout.
REQ-022 WB asserts run=1 for exactly one cycle, increments retired, and returns to FETCH.
- WB asserts RegWrite=1 only for R, I-ALU, LW, JAL, JALR, LUI and AUIPC.
REQ-023 RegWrite and run are asserted together in WB only, so PC+4 and PC+imm writebacks use the pre-update PC.
REQ-024 PCsrc in WB: 01 for JAL or a taken branch, 10 for JALR, 00 otherwise; PCsrc is 00 in every other state.
REQ-025 Writeback select:
- MemtoReg is 110 for LW, 001 for JAL/JALR, 010 for LUI, 011 for AUIPC, and 111 for SLT/SLTI (funct3 010).
- MemtoReg is 000 otherwise.
REQ-026 ALUctl: SUB for branches and SLT/SLTI, ADD for loads, stores, JALR and ADDI/ADD with funct7[5]=0, SUB for R-type with funct7[5]=1, AND for funct3 111, OR for funct3 110.
REQ-027 ALUsrc=1 for I-type, LW, SW and JALR; ALUsrc=0 otherwise.
REQ-028 Latency: 4 cycles FETCH-to-WB inclusive for non-memory instructions; 5 cycles plus ack wait for LW/SW.
REQ-029 busy=1 in every state except IDLE and HALT; halted=1 in HALT.
REQ-030 HALT is absorbing; only reset leaves it, and start is ignored there.
REQ-031 retired wraps modulo 2^W.
REQ-032 dm_ack outside MEM is ignored; start outside IDLE is ignored.
REQ-033 Control outputs are Moore functions of state, IR and the latched taken flag; outputs are zero in IDLE, FETCH, DECODE and HALT.

Reset
REQ-034 rst=0 forces IDLE immediately; IR, taken, retired, illegal and all outputs go to 0, including in mid-instruction or mid-MEM.
REQ-035 Deassertion of rst is synchronised externally; the first active edge after deassertion evaluates from IDLE.

Structure
REQ-036 A shared package holds the state enumeration, opcode constants, ALUctl codes (AND 000, OR 001, ADD 010, SUB 110) and MemtoReg codes, shared with the datapath.
REQ-037 A sub-module ctl_decode (combinational: IR and taken to ALUctl, ALUsrc, MemtoReg, PCsrc and class bits) is instantiated once.

Verification
REQ-038 Reset then start, IR=ADDI x1,x0,5 (0x00500093): FETCH, DECODE, EXEC, WB with ALUsrc=1 and ALUctl=010; WB has run=1, RegWrite=1, MemtoReg=000, PCsrc=00; retired=1.
REQ-039 BEQ with ALUzero=1 in EXEC: WB has PCsrc=01, RegWrite=0. BNE with ALUzero=1: PCsrc=00.
REQ-040 LW with dm_ack delayed 3 cycles: dm_req=1 for 4 cycles, dm_we=0; WB has MemtoReg=110, RegWrite=1. SW: dm_we=1 throughout MEM, RegWrite=0 in WB.
REQ-041 JALR (0x000080E7): ALUsrc=1; WB has PCsrc=10, MemtoReg=001, RegWrite=1.
REQ-042 EBREAK (0x00100073): halted=1, busy=0, run stays 0; a further start pulse has no effect. Opcode 0x7F: halted=1, illegal=1.
REQ-043 rst=0 asserted during a MEM wait: all outputs return to 0 immediately and the state is IDLE; a later start begins at FETCH with retired=0.
